// File: rtl/arith_result_accumulator.sv
// Batch accumulator for 6-bit add/multiply results: sums NUM_OPS beats modulo
// 2^ACC_W and presents the total with sticky overflow and mixed-kind flags.
module arith_result_accumulator #(
  parameter int unsigned NUM_OPS = 8,
  parameter int unsigned ACC_W   = 8,
  localparam int unsigned CNT_W  = $clog2(NUM_OPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_data,
  input  logic             in_is_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow,
  output logic             out_mixed
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             mixed;
  logic             kind;

  logic             accept;
  logic [ACC_W-1:0] data_ext;
  logic [ACC_W:0]   sum;
  logic [CNT_W-1:0] count_nxt;
  logic             last_beat;

  assign in_ready  = (state != S_DONE) & ~clear & ~rst;
  assign accept    = in_valid & in_ready;
  assign data_ext  = {{(ACC_W - 6){1'b0}}, in_data};
  assign sum       = {1'b0, acc} + {1'b0, data_ext};
  assign count_nxt = count + CNT_W'(1);
  assign last_beat = (count_nxt == CNT_W'(NUM_OPS));

  // Outputs come straight from state/registers; nothing combinational reaches them.
  assign out_valid    = (state == S_DONE);
  assign out_acc      = acc;
  assign out_count    = count;
  assign out_overflow = overflow;
  assign out_mixed    = mixed;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state    <= S_IDLE;
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
      mixed    <= 1'b0;
      kind     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc      <= data_ext;
            count    <= CNT_W'(1);
            kind     <= in_is_sum;
            overflow <= 1'b0;
            mixed    <= 1'b0;
            state    <= (NUM_OPS == 1) ? S_DONE : S_ACC;
          end
        end
        S_ACC: begin
          if (accept) begin
            acc      <= sum[ACC_W-1:0];
            overflow <= overflow | sum[ACC_W];
            mixed    <= mixed | (in_is_sum != kind);
            count    <= count_nxt;
            if (last_beat) state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_result_accumulator.sv
// Randomized and directed bench for arith_result_accumulator against a
// queue-based batch model.
module tb_arith_result_accumulator;

  localparam int unsigned NUM_OPS = 8;
  localparam int unsigned ACC_W   = 8;
  localparam int unsigned CNT_W   = $clog2(NUM_OPS + 1);

  logic             clk;
  logic             rst;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_data;
  logic             in_is_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_overflow;
  logic             out_mixed;

  arith_result_accumulator #(.NUM_OPS(NUM_OPS), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_is_sum(in_is_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_count(out_count), .out_overflow(out_overflow), .out_mixed(out_mixed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: the beats of the current batch, and whether it is complete.
  int m_data[$];
  bit m_kind[$];
  bit m_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_total();
    int s = 0;
    foreach (m_data[i]) s += m_data[i];
    return s;
  endfunction

  function automatic bit model_mixed();
    bit m = 1'b0;
    foreach (m_kind[i]) if (m_kind[i] != m_kind[0]) m = 1'b1;
    return m;
  endfunction

  // One clock: drive at negedge, check outputs, then advance the model at posedge.
  task automatic cycle(input bit r, input bit c, input bit v, input logic [5:0] d,
                       input bit k, input bit ordy);
    int tot;
    @(negedge clk);
    rst = r; clear = c; in_valid = v; in_data = d; in_is_sum = k; out_ready = ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'(!m_done && !c && !r));
    check("out_valid", 32'(out_valid), 32'(m_done));
    if (m_done) begin
      tot = model_total();
      check("out_acc", 32'(out_acc), 32'(tot % (1 << ACC_W)));
      check("out_count", 32'(out_count), 32'(m_data.size()));
      check("out_overflow", 32'(out_overflow), 32'(tot >= (1 << ACC_W)));
      check("out_mixed", 32'(out_mixed), 32'(model_mixed()));
    end
    @(posedge clk);
    if (r || c) begin
      m_data.delete(); m_kind.delete(); m_done = 1'b0;
    end else if (m_done) begin
      if (ordy) begin
        m_data.delete(); m_kind.delete(); m_done = 1'b0;
      end
    end else if (v) begin
      m_data.push_back(int'(d)); m_kind.push_back(k);
      if (m_data.size() == NUM_OPS) m_done = 1'b1;
    end
  endtask

  task automatic beat(input logic [5:0] d, input bit k);
    cycle(1'b0, 1'b0, 1'b1, d, k, 1'b1);
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, ordy);
  endtask

  task automatic do_clear();
    cycle(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  // Literal expectations, sampled shortly after the edge that followed the last cycle().
  task automatic expect_total(input string tag, input int v, input int acc, input int cnt,
                              input int ov, input int mx);
    #2;
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_acc"}, 32'(out_acc), 32'(acc));
    check({tag, "_count"}, 32'(out_count), 32'(cnt));
    check({tag, "_ovf"}, 32'(out_overflow), 32'(ov));
    check({tag, "_mixed"}, 32'(out_mixed), 32'(mx));
  endtask

  initial begin
    bit rk;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_is_sum = 1'b0; out_ready = 1'b0;

    cycle(1'b1, 1'b0, 1'b1, 6'd9, 1'b1, 1'b0);
    expect_total("reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 8; i++) beat(6'd5, 1'b1);
    expect_total("sum5", 1, 40, 8, 0, 0);
    idle(1'b1);

    for (int i = 0; i < 8; i++) beat(6'd49, 1'b0);
    expect_total("prod49", 1, 136, 8, 1, 0);
    idle(1'b1);

    for (int i = 0; i < 8; i++) beat(6'd3, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 6'd7, 1'b1, 1'b0);
    expect_total("stall", 1, 24, 8, 0, 0);
    cycle(1'b0, 1'b0, 1'b1, 6'd7, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 6'd7, 1'b1, 1'b1);
    expect_total("restart", 0, 7, 1, 0, 0);
    do_clear();

    for (int i = 0; i < 3; i++) beat(6'd10, 1'b1);
    do_clear();
    for (int i = 0; i < 8; i++) beat(6'd1, 1'b1);
    expect_total("after_clear", 1, 8, 8, 0, 0);
    idle(1'b1);

    for (int i = 0; i < 8; i++) beat(6'd2, (i % 2) == 0);
    expect_total("alt", 1, 16, 8, 0, 1);
    idle(1'b1);
    for (int i = 0; i < 8; i++) beat(6'd3, 1'b0);
    expect_total("uniform", 1, 24, 8, 0, 0);
    idle(1'b0);

    cycle(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1);
    expect_total("clear_done", 0, 0, 0, 0, 0);

    for (int i = 0; i < 8; i++) beat(6'd4, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 6'd4, 1'b1, 1'b0);
    expect_total("rst_done", 0, 0, 0, 0, 0);
    beat(6'd6, 1'b1);
    expect_total("post_rst", 0, 6, 1, 0, 0);

    rk = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) rk = ~rk;
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 9) < 7, 6'($urandom_range(0, 63)), rk,
            $urandom_range(0, 9) < 6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
